// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm
//   Multi-cycle sequencer for the KGP_RISC data_path. Each instruction walks
//   FETCH -> DECODE -> EXEC -> (MEM) -> (WB); the decoded control fields are
//   captured in DECODE and held until the next DECODE, strobes are decoded
//   from the current state.
//   Optional macro KGP_PERF_CNT_EN adds retired-instruction and busy-cycle
//   counters (instr_retired, cycle_count).
module multicycle_control_fsm #(
  parameter int unsigned FETCH_WAIT = 1,
  parameter int unsigned MEM_WAIT   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [5:0] opcode,
  input  logic [5:0] funccode,
  output logic [1:0] reg_dest,
  output logic       reg_write,
  output logic [2:0] ALUop,
  output logic [1:0] ALUsource,
  output logic       mem_write,
  output logic [1:0] mem_to_reg,
  output logic [2:0] branch,
  output logic       pc_en,
  output logic       ir_load,
  output logic       halted,
  output logic       illegal
`ifdef KGP_PERF_CNT_EN
  ,
  output logic [31:0] instr_retired,
  output logic [31:0] cycle_count
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    C_ALU, C_LW, C_SW, C_BR, C_NOP
  } cls_t;

  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_ADDI   = 6'b000001;
  localparam logic [5:0] OP_COMPI  = 6'b000010;
  localparam logic [5:0] OP_LW     = 6'b000100;
  localparam logic [5:0] OP_SW     = 6'b000101;
  localparam logic [5:0] OP_BRANCH = 6'b000110;
  localparam logic [5:0] OP_HALT   = 6'b111111;
  localparam logic [2:0] BR_LINK   = 3'b110;

  localparam logic [2:0] LP_FW = 3'(FETCH_WAIT);
  localparam logic [2:0] LP_MW = 3'(MEM_WAIT);

  state_t     r_state;
  state_t     w_next;
  logic [2:0] r_wait;
  cls_t       r_cls;
  logic [1:0] r_reg_dest;
  logic [2:0] r_alu_op;
  logic [1:0] r_alu_src;
  logic [1:0] r_mem_to_reg;
  logic [2:0] r_branch;
  logic       r_illegal;
  logic       w_unused;

  // Upper function-code bits carry no control information.
  assign w_unused = ^funccode[5:4];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Wait counter: counts cycles spent in FETCH/MEM, cleared on every state change.
  always_ff @(posedge clk) begin
    if (rst)                                          r_wait <= 3'd0;
    else if (w_next != r_state)                       r_wait <= 3'd0;
    else if (r_state == S_FETCH || r_state == S_MEM) r_wait <= r_wait + 3'd1;
    else                                              r_wait <= 3'd0;
  end

  // Decode: capture control fields in DECODE, hold them until the next DECODE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cls        <= C_NOP;
      r_reg_dest   <= 2'b00;
      r_alu_op     <= 3'b000;
      r_alu_src    <= 2'b00;
      r_mem_to_reg <= 2'b00;
      r_branch     <= 3'b000;
      r_illegal    <= 1'b0;
    end else if (r_state == S_DECODE) begin
      r_cls        <= C_NOP;
      r_reg_dest   <= 2'b00;
      r_alu_op     <= 3'b000;
      r_alu_src    <= 2'b00;
      r_mem_to_reg <= 2'b00;
      r_branch     <= 3'b000;
      case (opcode)
        OP_RTYPE: begin
          r_cls      <= C_ALU;
          r_alu_op   <= funccode[2:0];
          r_alu_src  <= funccode[3] ? 2'b10 : 2'b00;
          r_reg_dest <= 2'b01;
        end
        OP_ADDI: begin
          r_cls     <= C_ALU;
          r_alu_src <= 2'b01;
        end
        OP_COMPI: begin
          r_cls     <= C_ALU;
          r_alu_op  <= 3'b001;
          r_alu_src <= 2'b01;
        end
        OP_LW: begin
          r_cls        <= C_LW;
          r_alu_src    <= 2'b01;
          r_mem_to_reg <= 2'b01;
        end
        OP_SW: begin
          r_cls     <= C_SW;
          r_alu_src <= 2'b01;
        end
        OP_BRANCH: begin
          r_cls    <= C_BR;
          r_branch <= funccode[2:0];
          if (funccode[2:0] == BR_LINK) begin
            r_reg_dest   <= 2'b10;
            r_mem_to_reg <= 2'b10;
          end
        end
        OP_HALT: r_cls <= C_NOP;
        default: r_illegal <= 1'b1;
      endcase
    end
  end

  // Next-state and strobe decode.
  always_comb begin
    w_next    = r_state;
    ir_load   = 1'b0;
    pc_en     = 1'b0;
    reg_write = 1'b0;
    mem_write = 1'b0;
    halted    = 1'b0;
    branch    = 3'b000;
    case (r_state)
      S_IDLE: begin
        if (run) w_next = S_FETCH;
      end
      S_FETCH: begin
        if (r_wait == LP_FW) begin
          ir_load = 1'b1;
          w_next  = S_DECODE;
        end
      end
      S_DECODE: begin
        w_next = (opcode == OP_HALT) ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        case (r_cls)
          C_BR, C_NOP: begin
            pc_en     = 1'b1;
            branch    = r_branch;
            reg_write = (r_cls == C_BR) && (r_branch == BR_LINK);
            w_next    = run ? S_FETCH : S_IDLE;
          end
          C_LW, C_SW: w_next = S_MEM;
          default:    w_next = S_WB;
        endcase
      end
      S_MEM: begin
        mem_write = (r_cls == C_SW) && (r_wait == 3'd0);
        if (r_wait == LP_MW) begin
          if (r_cls == C_SW) begin
            pc_en  = 1'b1;
            w_next = run ? S_FETCH : S_IDLE;
          end else begin
            w_next = S_WB;
          end
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        pc_en     = 1'b1;
        w_next    = run ? S_FETCH : S_IDLE;
      end
      S_HALT: halted = 1'b1;
      default: w_next = S_IDLE;
    endcase
  end

  assign reg_dest   = r_reg_dest;
  assign ALUop      = r_alu_op;
  assign ALUsource  = r_alu_src;
  assign mem_to_reg = r_mem_to_reg;
  assign illegal    = r_illegal;

`ifdef KGP_PERF_CNT_EN
  // Performance counters: retired instructions and busy (non-IDLE/HALT) cycles; free-running wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_retired <= 32'd0;
      cycle_count   <= 32'd0;
    end else begin
      if (pc_en) instr_retired <= instr_retired + 32'd1;
      if (r_state != S_IDLE && r_state != S_HALT) cycle_count <= cycle_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Testbench for multicycle_control_fsm: scoreboard of per-instruction expectations.
module tb_multicycle_control_fsm;

  localparam int FW = 1;
  localparam int MW = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic [5:0] opcode;
  logic [5:0] funccode;
  logic [1:0] reg_dest;
  logic       reg_write;
  logic [2:0] ALUop;
  logic [1:0] ALUsource;
  logic       mem_write;
  logic [1:0] mem_to_reg;
  logic [2:0] branch;
  logic       pc_en;
  logic       ir_load;
  logic       halted;
  logic       illegal;
`ifdef KGP_PERF_CNT_EN
  logic [31:0] instr_retired;
  logic [31:0] cycle_count;
`endif

  multicycle_control_fsm #(.FETCH_WAIT(FW), .MEM_WAIT(MW)) dut (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode), .funccode(funccode),
    .reg_dest(reg_dest), .reg_write(reg_write), .ALUop(ALUop), .ALUsource(ALUsource),
    .mem_write(mem_write), .mem_to_reg(mem_to_reg), .branch(branch), .pc_en(pc_en),
    .ir_load(ir_load), .halted(halted), .illegal(illegal)
`ifdef KGP_PERF_CNT_EN
    , .instr_retired(instr_retired), .cycle_count(cycle_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cpi;
    int         ir_n;
    int         rw_n;
    int         mw_n;
    int         br_cnt;
    logic [2:0] br;
    logic [1:0] rd;
    logic [1:0] m2r;
    logic [2:0] alu;
    logic [1:0] src;
    logic       ill;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  logic exp_ill = 1'b0;

  int clr_gen = 0;
  int clr_seen = 0;
  int ret_cnt = 0;
  int pc_total = 0, mw_total = 0, rw_total = 0, ir_total = 0;
  int n = 0, ir_n = 0, ir_cnt = 0, rw_n = 0, rw_cnt = 0, mw_n = 0, mw_cnt = 0, br_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] all_outs();
    return {reg_dest, reg_write, ALUop, ALUsource, mem_write, mem_to_reg,
            branch, pc_en, ir_load, halted, illegal};
  endfunction

  // Expected behaviour of one instruction, straight from the decode table and CPI rules.
  function automatic exp_t build_exp(input logic [5:0] op, input logic [5:0] fc);
    exp_t e;
    e.ir_n = 1 + FW; e.rw_n = 0; e.mw_n = 0; e.br_cnt = 0; e.br = 3'b000;
    e.rd = 2'b00; e.m2r = 2'b00; e.alu = 3'b000; e.src = 2'b00;
    e.cpi = 3 + FW;
    case (op)
      6'b000000: begin
        e.cpi = 4 + FW; e.rw_n = e.cpi; e.rd = 2'b01;
        e.alu = fc[2:0]; e.src = fc[3] ? 2'b10 : 2'b00;
      end
      6'b000001: begin e.cpi = 4 + FW; e.rw_n = e.cpi; e.src = 2'b01; end
      6'b000010: begin e.cpi = 4 + FW; e.rw_n = e.cpi; e.src = 2'b01; e.alu = 3'b001; end
      6'b000100: begin e.cpi = 5 + FW + MW; e.rw_n = e.cpi; e.src = 2'b01; e.m2r = 2'b01; end
      6'b000101: begin e.cpi = 4 + FW + MW; e.mw_n = FW + 4; e.src = 2'b01; end
      6'b000110: begin
        e.br = fc[2:0];
        e.br_cnt = (fc[2:0] != 3'b000) ? 1 : 0;
        if (fc[2:0] == 3'b110) begin e.rw_n = e.cpi; e.rd = 2'b10; e.m2r = 2'b10; end
      end
      default: exp_ill = 1'b1;
    endcase
    e.ill = exp_ill;
    return e;
  endfunction

  // Monitor: accumulate strobes per instruction and score at each pc_en.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (clr_gen != clr_seen) begin
      clr_seen = clr_gen;
      n = 0; ir_n = 0; ir_cnt = 0; rw_n = 0; rw_cnt = 0; mw_n = 0; mw_cnt = 0; br_cnt = 0;
    end
    n++;
    if (ir_load)   begin ir_cnt++; ir_n = n; ir_total++; end
    if (reg_write) begin rw_cnt++; rw_n = n; rw_total++; end
    if (mem_write) begin mw_cnt++; mw_n = n; mw_total++; end
    if (branch != 3'b000) br_cnt++;
    if (pc_en) begin
      pc_total++;
      if (sb_q.size() == 0) begin
        check_eq("pc_en_unexpected", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check_eq("cpi", n, e.cpi);
        check_eq("ir_load_cycle", ir_n, e.ir_n);
        check_eq("ir_load_count", ir_cnt, 1);
        check_eq("reg_write_cycle", rw_n, e.rw_n);
        check_eq("reg_write_count", rw_cnt, (e.rw_n != 0) ? 1 : 0);
        check_eq("mem_write_cycle", mw_n, e.mw_n);
        check_eq("mem_write_count", mw_cnt, (e.mw_n != 0) ? 1 : 0);
        check_eq("branch_cycles", br_cnt, e.br_cnt);
        check_eq("branch", {29'd0, branch}, {29'd0, e.br});
        check_eq("fields", {18'd0, reg_dest, mem_to_reg, ALUop, ALUsource},
                 {18'd0, e.rd, e.m2r, e.alu, e.src});
        check_eq("illegal", {31'd0, illegal}, {31'd0, e.ill});
      end
      ret_cnt++;
      n = 0; ir_n = 0; ir_cnt = 0; rw_n = 0; rw_cnt = 0; mw_n = 0; mw_cnt = 0; br_cnt = 0;
    end
  end

  task automatic wait_retire(input int target);
    bit done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (ret_cnt >= target) done = 1;
    end
    if (!done) check_eq("retire_timeout", ret_cnt, target);
  endtask

  task automatic issue(input logic [5:0] op, input logic [5:0] fc);
    int t;
    opcode = op; funccode = fc;
    sb_q.push_back(build_exp(op, fc));
    t = ret_cnt + 1;
    wait_retire(t);
  endtask

  task automatic start_run();
    run = 1'b1;
    clr_gen++;
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1; run = 1'b0;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int p0, m0, r0, i0;
    rst = 1'b1; run = 1'b0; opcode = 6'd0; funccode = 6'd0;
    do_reset(3);

    // Idle after reset: everything stays low.
    for (int i = 0; i < 10; i++) begin
      check_eq("idle_outputs", {14'd0, all_outs()}, 32'd0);
      @(negedge clk);
    end

    // Back-to-back instruction stream.
    start_run();
    issue(6'b000000, 6'b001010);
    issue(6'b000001, 6'b000000);
    issue(6'b000010, 6'b000000);
    issue(6'b000000, 6'b000011);
    issue(6'b000100, 6'b000000);
    issue(6'b000101, 6'b000000);
    issue(6'b000110, 6'b000110);
    issue(6'b000110, 6'b000011);

    // run dropped mid-lw: lw completes, then the sequencer idles.
    opcode = 6'b000100; funccode = 6'd0;
    sb_q.push_back(build_exp(6'b000100, 6'd0));
    repeat (3) @(negedge clk);
    run = 1'b0;
    wait_retire(9);
    p0 = pc_total; i0 = ir_total;
    repeat (8) @(negedge clk);
    check_eq("drop_no_pc_en", pc_total, p0);
    check_eq("drop_no_fetch", ir_total, i0);
    check_eq("drop_not_halted", {31'd0, halted}, 32'd0);

    // Reset just before MEM of a sw: no mem_write, no retirement.
    p0 = pc_total; m0 = mw_total; i0 = ir_total;
    opcode = 6'b000101; funccode = 6'd0;
    start_run();
    repeat (4) @(negedge clk);
    rst = 1'b1; run = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check_eq("abort_fetched", ir_total, i0 + 1);
    check_eq("abort_no_mem_write", mw_total, m0);
    check_eq("abort_no_pc_en", pc_total, p0);
    check_eq("abort_outputs", {14'd0, all_outs()}, 32'd0);

    // Illegal opcode then halt.
    start_run();
    issue(6'b101010, 6'b000000);
    check_eq("retired_illegal", ret_cnt, 10);
    opcode = 6'b111111; funccode = 6'd0;
    repeat (8) @(negedge clk);
    p0 = pc_total; m0 = mw_total; r0 = rw_total; i0 = ir_total;
    repeat (6) @(negedge clk);
    check_eq("halted", {31'd0, halted}, 32'd1);
    check_eq("illegal_sticky", {31'd0, illegal}, 32'd1);
    check_eq("halt_strobes", pc_total + mw_total + rw_total + ir_total, p0 + m0 + r0 + i0);
    check_eq("halt_queue_empty", sb_q.size(), 0);
`ifdef KGP_PERF_CNT_EN
    check_eq("instr_retired", instr_retired, pc_total);
`endif

    // Reset leaves HALT and clears the sticky flag.
    do_reset(1);
    @(negedge clk);
    check_eq("post_halt_reset", {14'd0, all_outs()}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
